switch_alloc: RTL and testbench
===============================

# switch_alloc

Separable input-first switch allocator for the virtual-channel router, between VC allocation and buffer read/switch traversal. Each cycle it picks at most one input VC per input port and at most one input port per output port. It checks downstream credit for the allocated output VC and issues registered grants that drive buffer read, crossbar select and credit decrement.

## Interface
- NUM_PORTS, 5, router ports; port 0 is local.
- NUM_VC, 4, VCs per port.
- PORT_BITS, $clog2(NUM_PORTS), derived.
- VC_BITS, $clog2(NUM_VC), derived.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_PORTS*NUM_VC  input VC i*NUM_VC+v has a head flit with an allocated output VC.
- req_port  in  [NUM_PORTS*NUM_VC][PORT_BITS]  requested output port per input VC.
- req_out_vc  in  [NUM_PORTS*NUM_VC][VC_BITS]  allocated output VC per input VC.
- credit_avail  in  [NUM_PORTS][NUM_VC]  1 = output VC holds ≥1 downstream credit.
- credit_consume  out  [NUM_PORTS][NUM_VC]  combinational one-cycle decrement pulse for the output VC won this cycle.
- grant_valid  out  NUM_PORTS  registered; input port p won the switch.
- grant_vc  out  [NUM_PORTS][VC_BITS]  registered winning VC of input port p (buffer read index).
- xbar_valid  out  NUM_PORTS  registered; output port o assigned.
- xbar_sel  out  [NUM_PORTS][PORT_BITS]  registered input port driving output o.

## Operation
- Eligibility of input VC k:
  - req_valid[k];
  - credit_avail[req_port[k]][req_out_vc[k]];
  - k not granted at the previous edge (in-flight mask, prevents double grant of the same head flit).
- Stage 1, per input port: round-robin among eligible VCs using in_ptr[p]. Produces a candidate VC and its requested port.
- Stage 2, per output port: round-robin among input ports whose candidate requests it, using out_ptr[o].
- Pointer update happens only on a final grant:
  - in_ptr[p] moves to the winning VC + 1;
  - out_ptr[o] moves to the winning input + 1;
  - both wrap NUM_VC-1→0 and NUM_PORTS-1→0.
- A stage-1 winner that loses stage 2 leaves in_ptr[p] unchanged.
- credit_consume is asserted in the allocation cycle for the won output VC, so the external credit counter and the grant registers update on the same edge.
- At most one credit_consume bit is asserted per output port.
- Two input VCs requesting the same output VC in the same cycle is illegal (VC allocation guarantees this). No check is made.
- No requests: all grant/xbar valids deassert next cycle and pointers hold.

## Timing
- Request sampled in cycle N → grant_valid/grant_vc/xbar_* valid in cycle N+1. Latency is 1 cycle. Throughput is one grant per input and per output every cycle.
- The in-flight mask makes the same VC ineligible in cycle N+1. It is eligible again in N+2 if its next flit is present and credit remains.
- Reset (async assert): all registered outputs and the in-flight mask go to 0; in_ptr and out_ptr go to 0. This takes effect immediately, including mid-operation. credit_consume follows its inputs and is forced to 0 while reset is low.
- First grant after reset release: on the first edge with reset high.

## Configuration
- SA_CREDIT_CHECK_EN defined: eligibility requires credit_avail, and credit_consume is driven as above.
- SA_CREDIT_CHECK_EN undefined: credit_avail is ignored and credit_consume is tied to 0. Use this for testing with infinite buffering.

## Structure
- The shared package vr_pkg holds:
  - defaults for NUM_PORTS and NUM_VC;
  - PORT_BITS and VC_BITS derivation;
  - the flit-field constants already used for the VC index and destination.
- Sub-module rr_arbiter (parameter N): request vector, pointer, update enable in; one-hot grant, encoded index and registered pointer out. It has its own reset.
  - Instantiated NUM_PORTS times for stage 1 (N=NUM_VC).
  - Instantiated NUM_PORTS times for stage 2 (N=NUM_PORTS).

## Test plan
- Reset mid-run with grants pending → all outputs 0 in the same cycle. After release, a single request on port 1 VC 2 to output 3 gives grant_valid=00010, grant_vc[1]=2, xbar_sel[3]=1 one cycle later.
- Ports 1, 2 and 4, each VC 0, all request output 3 with credit, held high for 6 cycles → grants rotate 1, 2, 4, 1, 2, 4 (ignoring in-flight gaps, each port wins every third grant). Exactly one credit_consume[3][x] per cycle.
- Port 2 VCs 0–3 request distinct outputs 1–4 continuously → grant_vc[2] follows 0, 1, 2, 3, 0, with wrap-around. The same VC is never granted on consecutive cycles.
- credit_avail[2][1]=0 for a request to output 2 VC 1 → no grant and no consume. Setting credit_avail to 1 → grant the next cycle.
- All 5 ports request distinct outputs in the same cycle → all five grant_valid and xbar_valid bits are 1 next cycle, with a correct permutation in xbar_sel.
- SA_CREDIT_CHECK_EN undefined, all credit_avail=0 → grants are still issued and credit_consume stays 0.

Source files
------------

// File: rtl/vr_pkg.sv
// rtl/vr_pkg.sv - shared router sizing defaults and flit-field constants
package vr_pkg;

  localparam int NUM_PORTS_DEF = 5;
  localparam int NUM_VC_DEF    = 4;
  localparam int PORT_BITS     = $clog2(NUM_PORTS_DEF);
  localparam int VC_BITS       = $clog2(NUM_VC_DEF);

  localparam int FLIT_W        = 64;
  localparam int FLIT_VC_LSB   = 0;
  localparam int FLIT_VC_W     = VC_BITS;
  localparam int FLIT_DEST_LSB = FLIT_VC_LSB + FLIT_VC_W;
  localparam int FLIT_DEST_W   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; pointer advances past the winner on update
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_upd,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic [IW-1:0] o_ptr
);

  logic [IW-1:0] r_ptr;
  logic          w_any;

  assign w_any = |i_req;
  assign o_ptr = r_ptr;

  // Scan from the pointer upwards with wrap; first requester wins.
  always_comb begin
    int            j;
    logic          found;
    logic [IW-1:0] jj;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && i_req[jj]) begin
        found       = 1'b1;
        o_grant[jj] = 1'b1;
        o_idx       = jj;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_upd && w_any) begin
      r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/switch_alloc.sv
// rtl/switch_alloc.sv - separable input-first switch allocator with registered grants
// SA_CREDIT_CHECK_EN: gate eligibility on downstream credit and drive credit_consume.
module switch_alloc
  import vr_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int NUM_VC    = NUM_VC_DEF,
  parameter int PORT_BITS = $clog2(NUM_PORTS),
  parameter int VC_BITS   = $clog2(NUM_VC)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [NUM_PORTS*NUM_VC-1:0]               i_req_valid,
  input  logic [NUM_PORTS*NUM_VC-1:0][PORT_BITS-1:0] i_req_port,
  input  logic [NUM_PORTS*NUM_VC-1:0][VC_BITS-1:0]   i_req_out_vc,
  input  logic [NUM_PORTS-1:0][NUM_VC-1:0]           i_credit_avail,
  output logic [NUM_PORTS-1:0][NUM_VC-1:0]           o_credit_consume,
  output logic [NUM_PORTS-1:0]                       o_grant_valid,
  output logic [NUM_PORTS-1:0][VC_BITS-1:0]          o_grant_vc,
  output logic [NUM_PORTS-1:0]                       o_xbar_valid,
  output logic [NUM_PORTS-1:0][PORT_BITS-1:0]        o_xbar_sel
);

  localparam int NK = NUM_PORTS * NUM_VC;

  logic [NK-1:0]                       r_inflight;
  logic [NK-1:0]                       w_cred;
  logic [NK-1:0]                       w_elig;
  logic [NK-1:0]                       w_gnt_mask;
  logic [NUM_PORTS-1:0]                w_s1_any;
  logic [NUM_PORTS-1:0]                w_in_win;
  logic [NUM_PORTS-1:0]                w_out_busy;
  logic [NUM_PORTS-1:0][NUM_VC-1:0]    w_s1_grant;
  logic [NUM_PORTS-1:0][VC_BITS-1:0]   w_cand_vc;
  logic [NUM_PORTS-1:0][VC_BITS-1:0]   w_cand_ovc;
  logic [NUM_PORTS-1:0][PORT_BITS-1:0] w_cand_port;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_s2_req;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_s2_grant;
  logic [NUM_PORTS-1:0][PORT_BITS-1:0] w_s2_idx;
  logic [NUM_PORTS-1:0][VC_BITS-1:0]   w_s1_unused_ptr;
  logic [NUM_PORTS-1:0][PORT_BITS-1:0] w_s2_unused_ptr;

  logic [NUM_PORTS-1:0]                r_grant_valid;
  logic [NUM_PORTS-1:0][VC_BITS-1:0]   r_grant_vc;
  logic [NUM_PORTS-1:0]                r_xbar_valid;
  logic [NUM_PORTS-1:0][PORT_BITS-1:0] r_xbar_sel;

  always_comb begin
    w_cred = '1;
`ifdef SA_CREDIT_CHECK_EN
    for (int k = 0; k < NK; k++) begin
      w_cred[k] = (int'(i_req_port[k]) < NUM_PORTS) &&
                  i_credit_avail[i_req_port[k]][i_req_out_vc[k]];
    end
`endif
  end

  // A VC granted last edge is still reading its head flit; skip it for one cycle.
  assign w_elig = i_req_valid & w_cred & ~r_inflight;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [NUM_VC-1:0][PORT_BITS-1:0] w_port_of;
    logic [NUM_VC-1:0][VC_BITS-1:0]   w_ovc_of;

    rr_arbiter #(.N(NUM_VC)) u_in_arb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (w_elig[p*NUM_VC +: NUM_VC]),
      .i_upd   (w_in_win[p]),
      .o_grant (w_s1_grant[p]),
      .o_idx   (w_cand_vc[p]),
      .o_ptr   (w_s1_unused_ptr[p])
    );

    assign w_s1_any[p]    = |w_elig[p*NUM_VC +: NUM_VC];
    assign w_port_of      = i_req_port[p*NUM_VC +: NUM_VC];
    assign w_ovc_of       = i_req_out_vc[p*NUM_VC +: NUM_VC];
    assign w_cand_port[p] = w_port_of[w_cand_vc[p]];
    assign w_cand_ovc[p]  = w_ovc_of[w_cand_vc[p]];
    assign w_gnt_mask[p*NUM_VC +: NUM_VC] = w_s1_grant[p] & {NUM_VC{w_in_win[p]}};
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
      assign w_s2_req[o][p] = w_s1_any[p] && (w_cand_port[p] == PORT_BITS'(o));
    end

    rr_arbiter #(.N(NUM_PORTS)) u_out_arb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (w_s2_req[o]),
      .i_upd   (w_out_busy[o]),
      .o_grant (w_s2_grant[o]),
      .o_idx   (w_s2_idx[o]),
      .o_ptr   (w_s2_unused_ptr[o])
    );

    assign w_out_busy[o] = |w_s2_req[o];
  end

  always_comb begin
    w_in_win = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_in_win = w_in_win | w_s2_grant[o];
    end
  end

  always_comb begin
    o_credit_consume = '0;
`ifdef SA_CREDIT_CHECK_EN
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (i_rst_n && w_out_busy[o]) begin
        o_credit_consume[o][w_cand_ovc[w_s2_idx[o]]] = 1'b1;
      end
    end
`endif
  end

`ifndef SA_CREDIT_CHECK_EN
  logic w_unused_credit;
  assign w_unused_credit = ^{i_credit_avail, w_cand_ovc};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight    <= '0;
      r_grant_valid <= '0;
      r_grant_vc    <= '0;
      r_xbar_valid  <= '0;
      r_xbar_sel    <= '0;
    end else begin
      r_inflight    <= w_gnt_mask;
      r_grant_valid <= w_in_win;
      r_xbar_valid  <= w_out_busy;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_grant_vc[p] <= w_in_win[p] ? w_cand_vc[p] : '0;
        r_xbar_sel[p] <= w_out_busy[p] ? w_s2_idx[p] : '0;
      end
    end
  end

  assign o_grant_valid = r_grant_valid;
  assign o_grant_vc    = r_grant_vc;
  assign o_xbar_valid  = r_xbar_valid;
  assign o_xbar_sel    = r_xbar_sel;

endmodule

// File: tb/tb_switch_alloc.sv
// tb/tb_switch_alloc.sv - randomized bench for switch_alloc against a behavioural allocator model
module tb_switch_alloc;
  import vr_pkg::*;

  localparam int NP = NUM_PORTS_DEF;
  localparam int NV = NUM_VC_DEF;
  localparam int PB = PORT_BITS;
  localparam int VB = VC_BITS;
  localparam int NK = NP * NV;

  logic                   clk;
  logic                   rst_n;
  logic [NK-1:0]          req_valid;
  logic [NK-1:0][PB-1:0]  req_port;
  logic [NK-1:0][VB-1:0]  req_out_vc;
  logic [NP-1:0][NV-1:0]  credit_avail;
  logic [NP-1:0][NV-1:0]  credit_consume;
  logic [NP-1:0]          grant_valid;
  logic [NP-1:0][VB-1:0]  grant_vc;
  logic [NP-1:0]          xbar_valid;
  logic [NP-1:0][PB-1:0]  xbar_sel;

  int n_tests = 0;
  int n_fail  = 0;

  int m_in_ptr[NP];
  int m_out_ptr[NP];
  bit m_infl[NK];

  logic [NP-1:0]         e_gv;
  logic [NP-1:0]         e_xv;
  logic [NP-1:0][NV-1:0] e_cc;
  int                    e_gvc[NP];
  int                    e_xs[NP];

  switch_alloc u_dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (req_valid),
    .i_req_port       (req_port),
    .i_req_out_vc     (req_out_vc),
    .i_credit_avail   (credit_avail),
    .o_credit_consume (credit_consume),
    .o_grant_valid    (grant_valid),
    .o_grant_vc       (grant_vc),
    .o_xbar_valid     (xbar_valid),
    .o_xbar_sel       (xbar_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NP; i++) begin
      m_in_ptr[i]  = 0;
      m_out_ptr[i] = 0;
    end
    for (int k = 0; k < NK; k++) m_infl[k] = 1'b0;
  endtask

  function automatic bit m_elig(int k);
    bit c = 1'b1;
`ifdef SA_CREDIT_CHECK_EN
    c = (int'(req_port[k]) < NP) && credit_avail[req_port[k]][req_out_vc[k]];
`endif
    return req_valid[k] && !m_infl[k] && c;
  endfunction

  // Input-first separable allocation computed directly from the allocation rules.
  task automatic model_step();
    int cand[NP];
    bit nxt[NK];
    int v, q, k, win;
    e_gv = '0;
    e_xv = '0;
    e_cc = '0;
    for (int i = 0; i < NK; i++) nxt[i] = 1'b0;
    for (int p = 0; p < NP; p++) begin
      e_gvc[p] = 0;
      e_xs[p]  = 0;
      cand[p]  = -1;
      for (int i = 0; i < NV; i++) begin
        v = (m_in_ptr[p] + i) % NV;
        if (cand[p] < 0 && m_elig(p * NV + v)) cand[p] = v;
      end
    end
    for (int o = 0; o < NP; o++) begin
      win = -1;
      for (int i = 0; i < NP; i++) begin
        q = (m_out_ptr[o] + i) % NP;
        if (win < 0 && cand[q] >= 0 && int'(req_port[q * NV + cand[q]]) == o) win = q;
      end
      if (win >= 0) begin
        k = win * NV + cand[win];
        e_gv[win]      = 1'b1;
        e_gvc[win]     = cand[win];
        e_xv[o]        = 1'b1;
        e_xs[o]        = win;
        m_out_ptr[o]   = (win + 1) % NP;
        m_in_ptr[win]  = (cand[win] + 1) % NV;
        nxt[k]         = 1'b1;
`ifdef SA_CREDIT_CHECK_EN
        e_cc[o][req_out_vc[k]] = 1'b1;
`endif
      end
    end
    m_infl = nxt;
  endtask

  task automatic step(input string tag);
    #1;
    model_step();
    check({tag, " consume"}, 32'(credit_consume), 32'(e_cc));
    @(posedge clk);
    #1;
    check({tag, " grant_valid"}, 32'(grant_valid), 32'(e_gv));
    check({tag, " xbar_valid"}, 32'(xbar_valid), 32'(e_xv));
    for (int p = 0; p < NP; p++) begin
      if (e_gv[p]) check($sformatf("%s grant_vc[%0d]", tag, p), 32'(grant_vc[p]), e_gvc[p]);
      if (e_xv[p]) check($sformatf("%s xbar_sel[%0d]", tag, p), 32'(xbar_sel[p]), e_xs[p]);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " grant_valid"}, 32'(grant_valid), 0);
    check({tag, " grant_vc"}, 32'(grant_vc), 0);
    check({tag, " xbar_valid"}, 32'(xbar_valid), 0);
    check({tag, " xbar_sel"}, 32'(xbar_sel), 0);
    check({tag, " consume"}, 32'(credit_consume), 0);
  endtask

  task automatic clear_req();
    req_valid  = '0;
    req_port   = '0;
    req_out_vc = '0;
  endtask

  task automatic set_req(input int p, input int v, input int o, input int ovc);
    req_valid[p * NV + v]  = 1'b1;
    req_port[p * NV + v]   = PB'(o);
    req_out_vc[p * NV + v] = VB'(ovc);
  endtask

  // Each input VC gets a distinct output VC, so no two requesters share one.
  task automatic shuffle_routes();
    int perm[NK];
    int j, t;
    for (int i = 0; i < NK; i++) perm[i] = i;
    for (int i = NK - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < NK; k++) begin
      req_port[k]   = PB'(perm[k] / NV);
      req_out_vc[k] = VB'(perm[k] % NV);
    end
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 8 == 0) shuffle_routes();
      req_valid    = NK'($urandom);
      credit_avail = (NP * NV)'($urandom | $urandom);
      step("rand");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_req();
    credit_avail = '1;
    m_reset();
    #12;
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    rand_cycles(20);
    shuffle_routes();
    req_valid    = '1;
    credit_avail = '1;
    step("pre_reset");
    rst_n = 1'b0;
    #2;
    check_zero("mid_reset");
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    clear_req();
    credit_avail = '1;
    set_req(1, 2, 3, 0);
    step("single");
    check("single direct grant_valid", 32'(grant_valid), 32'b00010);
    check("single direct grant_vc1", 32'(grant_vc[1]), 2);
    check("single direct xbar_sel3", 32'(xbar_sel[3]), 1);

    clear_req();
    step("idle");

    set_req(1, 0, 3, 0);
    set_req(2, 0, 3, 1);
    set_req(4, 0, 3, 2);
    repeat (6) step("rotate");

    clear_req();
    for (int v = 0; v < NV; v++) set_req(2, v, v + 1, 0);
    repeat (6) step("vc_walk");

    clear_req();
    credit_avail       = '1;
    credit_avail[2][1] = 1'b0;
    set_req(0, 0, 2, 1);
    step("no_credit");
    credit_avail[2][1] = 1'b1;
    step("credit_back");
    step("credit_hold");

    clear_req();
    step("gap");
    for (int p = 0; p < NP; p++) set_req(p, 0, (p + 1) % NP, 0);
    step("perm");
    check("perm direct grant_valid", 32'(grant_valid), 32'h1f);
    check("perm direct xbar_valid", 32'(xbar_valid), 32'h1f);
    for (int o = 0; o < NP; o++)
      check($sformatf("perm direct xbar_sel[%0d]", o), 32'(xbar_sel[o]), (o + NP - 1) % NP);

`ifndef SA_CREDIT_CHECK_EN
    clear_req();
    step("gap2");
    credit_avail = '0;
    set_req(3, 1, 0, 2);
    step("ignore_credit");
    check("ignore_credit direct grant3", 32'(grant_valid[3]), 1);
`endif

    rand_cycles(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
